// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state type and defaults for the SPI request arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } arb_state_t;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_TIMEOUT_CYC = 1023;
  localparam int MIN_CNT_W       = 10;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select starting at ptr, wrapping
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        idx        = cand;
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin sharing of one SPI master; watchdog via SPI_ARB_TIMEOUT_EN
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      spi_newd,
  output logic [DATA_W-1:0]         spi_din,
  input  logic                      spi_cs
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state, state_n;
  logic [PW-1:0]       ptr, ptr_n, gidx, gidx_n;
  logic [NUM_REQ-1:0]  gnt_n, ack_n, p_pick;
  logic [PW-1:0]       p_idx;
  logic                p_valid;
  logic [DATA_W-1:0]   spi_din_n;
  logic                spi_newd_n, terr_n;
  logic                to_hit;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (p_pick),
    .idx   (p_idx),
    .valid (p_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > MIN_CNT_W) ? $clog2(TIMEOUT_CYC + 1) : MIN_CNT_W;
  logic [CNT_W-1:0] cnt, cnt_n;

  assign to_hit = (cnt == CNT_W'(TIMEOUT_CYC));

  // Held at zero outside the waiting states so ISSUE always starts from 0.
  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    if (state == IDLE || state == ACK)
      cnt_n = '0;
    else if (state == ISSUE && !spi_cs)
      cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_n;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign to_hit = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    gidx_n     = gidx;
    gnt_n      = gnt;
    ack_n      = '0;
    spi_din_n  = spi_din;
    spi_newd_n = spi_newd;
    terr_n     = 1'b0;
    case (state)
      IDLE: begin
        if (p_valid) begin
          state_n    = ISSUE;
          gnt_n      = p_pick;
          gidx_n     = p_idx;
          spi_newd_n = 1'b1;
          for (int i = 0; i < NUM_REQ; i++)
            if (p_pick[i]) spi_din_n = din[i*DATA_W +: DATA_W];
        end
      end
      ISSUE: begin
        if (to_hit) begin
          state_n    = ACK;
          spi_newd_n = 1'b0;
          ack_n      = gnt;
          terr_n     = 1'b1;
        end else if (!spi_cs) begin
          state_n    = WAIT_DONE;
          spi_newd_n = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (spi_cs) begin
          state_n = ACK;
          ack_n   = gnt;
        end else if (to_hit) begin
          state_n = ACK;
          ack_n   = gnt;
          terr_n  = 1'b1;
        end
      end
      ACK: begin
        state_n = IDLE;
        gnt_n   = '0;
        ptr_n   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      gnt         <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      spi_newd    <= 1'b0;
      spi_din     <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      gidx        <= gidx_n;
      gnt         <= gnt_n;
      ack         <= ack_n;
      timeout_err <= terr_n;
      spi_newd    <= spi_newd_n;
      spi_din     <= spi_din_n;
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 12;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_CYC = 20;
`else
  localparam int TO_CYC = 1023;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] din;
  logic                      spi_cs = 1'b1;
  logic [NUM_REQ-1:0]        gnt, ack;
  logic                      busy, timeout_err, spi_newd;
  logic [DATA_W-1:0]         spi_din;

  int total = 0;
  int bad   = 0;
  int onehot_viol = 0;

  spi_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .din         (din),
    .gnt         (gnt),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .spi_newd    (spi_newd),
    .spi_din     (spi_din),
    .spi_cs      (spi_cs)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && ($countones(gnt) > 1 || $countones(ack) > 1)) onehot_viol++;

  initial begin
    #1000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (gnt != '0) ok = 1'b1;
      else tick();
    end
    if (!ok) check("grant_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},  gnt, 0);
    check({tag, "_ack"},  ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_newd"}, spi_newd, 0);
    check({tag, "_din"},  spi_din, 0);
  endtask

  // drop: 0 keep req, 1 drop at ack, 2 drop while in WAIT_DONE
  task automatic do_txn(input string tag, input logic [3:0] exp_g, input logic [11:0] exp_w,
                        input int low, input int drop);
    bit ok;
    bit stable;
    wait_grant(ok);
    check({tag, "_gnt"},  gnt, exp_g);
    check({tag, "_din"},  spi_din, exp_w);
    check({tag, "_newd"}, spi_newd, 1);
    check({tag, "_busy"}, busy, 1);
    spi_cs = 1'b0;
    tick();
    check({tag, "_newd_fall"}, spi_newd, 0);
    stable = 1'b1;
    for (int i = 0; i < low; i++) begin
      if (i == 2 && drop == 2) req = req & ~exp_g;
      tick();
      if (spi_din !== exp_w || gnt !== exp_g || ack !== '0 || busy !== 1'b1) stable = 1'b0;
    end
    check({tag, "_hold"}, stable, 1);
    spi_cs = 1'b1;
    tick();
    check({tag, "_ack"},      ack, exp_g);
    check({tag, "_ack_gnt"},  gnt, exp_g);
    check({tag, "_ack_terr"}, timeout_err, 0);
    if (drop == 1) req = req & ~exp_g;
    tick();
    check({tag, "_ack_end"}, ack, 0);
    check({tag, "_gnt_end"}, gnt, 0);
    check({tag, "_idle"},    busy, 0);
  endtask

  initial begin
    bit ok;
    bit stable;
    din = {12'h3C3, 12'hA5C, 12'h2B7, 12'h1E4};

    rst = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;

    req = 4'b0100;
    do_txn("single", 4'b0100, 12'hA5C, 150, 1);

    rst = 1'b0; tick(); rst = 1'b1;
    req = 4'b1111;
    do_txn("rr0", 4'b0001, 12'h1E4, 5, 0);
    do_txn("rr1", 4'b0010, 12'h2B7, 5, 0);
    do_txn("rr2", 4'b0100, 12'hA5C, 5, 0);
    do_txn("rr3", 4'b1000, 12'h3C3, 5, 0);
    do_txn("rr4", 4'b0001, 12'h1E4, 5, 0);
    req = 4'b0000;
    tick();

    req = 4'b0100;
    do_txn("wrap_a", 4'b0100, 12'hA5C, 4, 1);
    req = 4'b1001;
    do_txn("wrap_b", 4'b1000, 12'h3C3, 4, 1);
    do_txn("wrap_c", 4'b0001, 12'h1E4, 4, 1);

    req = 4'b0010;
    do_txn("withdraw", 4'b0010, 12'h2B7, 8, 2);

    req = 4'b0100;
    wait_grant(ok);
    check("mid_rst_gnt", gnt, 4'b0100);
    spi_cs = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    req = 4'b0000;
    tick();
    rst = 1'b1;
    check_idle_outputs("mid_rst");
    spi_cs = 1'b1;
    tick();
    check("mid_rst_no_ack", ack, 0);
    req = 4'b1010;
    do_txn("post_rst", 4'b0010, 12'h2B7, 4, 1);
    req = 4'b0000;
    tick();

    req = 4'b1000;
    wait_grant(ok);
    check("to_gnt", gnt, 4'b1000);
    stable = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 0; i < TO_CYC; i++) begin
      tick();
      if (spi_newd !== 1'b1 || ack !== '0) stable = 1'b0;
    end
    check("to_wait", stable, 1);
    req = 4'b0000;
    tick();
    check("to_ack",  ack, 4'b1000);
    check("to_terr", timeout_err, 1);
    check("to_newd", spi_newd, 0);
    tick();
    check("to_terr_end", timeout_err, 0);
    check("to_idle", busy, 0);
`else
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (busy !== 1'b1 || spi_newd !== 1'b1 || ack !== '0 || timeout_err !== 1'b0) stable = 1'b0;
    end
    check("no_to_wait", stable, 1);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    rst = 1'b1;
    check("no_to_rst_busy", busy, 0);
`endif

    check("onehot", onehot_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
